true_dual_port_bram_pipe: RTL
=============================

// Module: true_dual_port_bram_pipe
// PURPOSE
//  Parametrised true dual-port block RAM, successor to the single-port sync BRAM used for
//  feature-map/weight buffering. Two independent ports (A,B) on one clock, per-byte write
//  enables, selectable same-port read-during-write mode, optional output pipeline register
//  and a read-valid flag per port so downstream conv/pool engines need no latency bookkeeping.
// PARAMETERS
//  DWIDTH    64    data width in bits; must be a multiple of 8
//  MEM_SIZE  2048  number of words; AWIDTH = clogb2(MEM_SIZE-1)
//  OUT_REG   1     0: read latency 1 cycle; 1: extra output register, latency 2
//  RDW_MODE  2     same-port read-during-write: 0 read-first (old), 1 write-first (new), 2 no-change
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  reset      in   1          asynchronous, active-high reset
//  addr_a     in   AWIDTH     port A word address
//  ce_a       in   1          port A enable; no access when low
//  we_a       in   DWIDTH/8   port A byte write enables; any bit set = write cycle
//  din_a      in   DWIDTH     port A write data
//  dout_a     out  DWIDTH     port A read data
//  dvalid_a   out  1          port A read data valid (single-cycle pulse per read)
//  addr_b, ce_b, we_b, din_b, dout_b, dvalid_b   same as port A, for port B
// BEHAVIOUR
//  - reset (async assert, sync deassert by caller): dout_a/b <= 0, dvalid_a/b <= 0, all
//    pipeline stages cleared; memory contents NOT cleared. Reads in flight are dropped (no valid).
//  - Read cycle: ce=1 and we==0. Data at addr appears on dout after 1+OUT_REG cycles with
//    dvalid=1 for exactly that cycle. Back-to-back reads fully pipelined, 1 per cycle per port.
//  - Write cycle: ce=1 and we!=0. Byte i (din[8i+7:8i]) written iff we[i]; other bytes kept.
//    Write cycle read behaviour by RDW_MODE:
//      0: dout = word before write, dvalid=1
//      1: dout = word after byte-merge, dvalid=1
//      2: dout holds previous value, dvalid=0 (no read issued)
//  - ce=0: dout holds last value (both register stages hold), dvalid=0 that slot.
//  - OUT_REG=1: stage-2 register captures stage-1 data/valid every cycle; dout holds when
//    stage-1 valid=0 so dout is stable between reads.
//  - Cross-port same address, same cycle:
//      A write + B write: per byte, port A wins where both we bits set; other bytes from their
//        writer. Port B write to those bytes is lost; no error flag.
//      One port writes, other reads: reader gets OLD word (pre-write), independent of RDW_MODE.
//  - addr >= MEM_SIZE (non-power-of-2 sizes): write ignored, read returns 0 with dvalid=1.
//  - No internal reset of addresses; inputs sampled only when ce=1.
//  - Infer block RAM (ram_style block); output registers must map into BRAM output regs.
// TESTING
//  1. reset=1 then release, no access -> dout_a=dout_b=0, dvalid=0 for 10 cycles.
//  2. OUT_REG=1: A writes 0x1111..11 @5, then A reads @5 -> dout_a=0x1111..11, dvalid_a
//     high exactly 2 cycles after read issue; 8 back-to-back reads give 8 consecutive valids.
//  3. Byte enables: mem[7]=0xFFFF_FFFF_FFFF_FFFF, B writes 0 with we_b=8'h0F @7, read ->
//     0xFFFF_FFFF_0000_0000.
//  4. RDW_MODE 0/1/2: mem[3]=0xAA.., write 0x55.. @3 on A -> dout_a = 0xAA.. / 0x55.. /
//     unchanged with dvalid_a=0 respectively.
//  5. Collision: same cycle A writes 0x01.. we=FF, B writes 0x02.. we=F0 @9 -> mem[9]=0x01..;
//     A writes @9 while B reads @9 -> B gets old word.
//  6. Reset mid-read: issue read, assert reset next cycle -> no dvalid pulse, dout=0 after reset.

Source files
------------

// File: rtl/true_dual_port_bram_pipe.sv
// True dual-port block RAM with per-byte write enables and a selectable same-port
// read-during-write mode. There is an optional output register, and each port has a
// read-valid pulse so that consumers need no latency bookkeeping.
module true_dual_port_bram_pipe #(
    parameter int unsigned DWIDTH   = 64,
    parameter int unsigned MEM_SIZE = 2048,
    parameter int unsigned OUT_REG  = 1,
    parameter int unsigned RDW_MODE = 2,
    localparam int unsigned AWIDTH  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
    localparam int unsigned NBYTES  = DWIDTH / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AWIDTH-1:0] addr_a,
    input  logic              ce_a,
    input  logic [NBYTES-1:0] we_a,
    input  logic [DWIDTH-1:0] din_a,
    output logic [DWIDTH-1:0] dout_a,
    output logic              dvalid_a,
    input  logic [AWIDTH-1:0] addr_b,
    input  logic              ce_b,
    input  logic [NBYTES-1:0] we_b,
    input  logic [DWIDTH-1:0] din_b,
    output logic [DWIDTH-1:0] dout_b,
    output logic              dvalid_b
);

    (* ram_style = "block" *) logic [DWIDTH-1:0] mem [MEM_SIZE];

    logic              in_range_a, in_range_b;
    logic              wr_a, wr_b, rd_a, rd_b;
    logic [DWIDTH-1:0] rd_word_a, rd_word_b;
    logic [DWIDTH-1:0] s1_data_a, s1_data_b;
    logic              s1_valid_a, s1_valid_b;

    function automatic logic [DWIDTH-1:0] byte_merge(input logic [DWIDTH-1:0] old_word,
                                                     input logic [DWIDTH-1:0] new_word,
                                                     input logic [NBYTES-1:0] be);
        logic [DWIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // An address range check is only needed when the depth is not a power of two.
    generate
        if (MEM_SIZE == 2**AWIDTH) begin : g_pow2
            assign in_range_a = 1'b1;
            assign in_range_b = 1'b1;
        end else begin : g_npow2
            assign in_range_a = (32'(addr_a) < MEM_SIZE);
            assign in_range_b = (32'(addr_b) < MEM_SIZE);
        end
    endgenerate

    // In no-change mode, a write cycle issues no read.
    assign wr_a = ce_a && (|we_a) && in_range_a;
    assign wr_b = ce_b && (|we_b) && in_range_b;
    assign rd_a = ce_a && ((we_a == '0) || (RDW_MODE != 2));
    assign rd_b = ce_b && ((we_b == '0) || (RDW_MODE != 2));

    // Byte-granular writes; port A is issued last, so it wins on overlapping bytes.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_b && we_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
            if (wr_a && we_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
        end
    end

    // Read word per port: this is the old contents, except for a same-port write-first merge.
    always_comb begin
        rd_word_a = in_range_a ? mem[addr_a] : '0;
        rd_word_b = in_range_b ? mem[addr_b] : '0;
        if (RDW_MODE == 1 && wr_a) rd_word_a = byte_merge(rd_word_a, din_a, we_a);
        if (RDW_MODE == 1 && wr_b) rd_word_b = byte_merge(rd_word_b, din_b, we_b);
    end

    // Stage-1 read registers hold their data when no read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_data_a  <= '0;
            s1_valid_a <= 1'b0;
            s1_data_b  <= '0;
            s1_valid_b <= 1'b0;
        end else begin
            s1_valid_a <= rd_a;
            s1_valid_b <= rd_b;
            if (rd_a) s1_data_a <= rd_word_a;
            if (rd_b) s1_data_b <= rd_word_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] s2_data_a, s2_data_b;
            logic              s2_valid_a, s2_valid_b;

            // The output register captures only valid data, so dout stays stable between reads.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_data_a  <= '0;
                    s2_valid_a <= 1'b0;
                    s2_data_b  <= '0;
                    s2_valid_b <= 1'b0;
                end else begin
                    s2_valid_a <= s1_valid_a;
                    s2_valid_b <= s1_valid_b;
                    if (s1_valid_a) s2_data_a <= s1_data_a;
                    if (s1_valid_b) s2_data_b <= s1_data_b;
                end
            end

            assign dout_a   = s2_data_a;
            assign dvalid_a = s2_valid_a;
            assign dout_b   = s2_data_b;
            assign dvalid_b = s2_valid_b;
        end else begin : g_no_out_reg
            assign dout_a   = s1_data_a;
            assign dvalid_a = s1_valid_a;
            assign dout_b   = s1_data_b;
            assign dvalid_b = s1_valid_b;
        end
    endgenerate

endmodule
